if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 138 +++++++++++++
 tb/tb_if_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch unit: in-order imem requests feeding a small decode buffer
//
// Purpose: issues sequential word fetches to instruction memory, buffers the
// returned words with their addresses and presents them to decode. A redirect
// from execute flushes the buffer and drops responses still in flight.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   fetch_en_i                  level enable for issuing new requests
//   imem_req_o / imem_addr_o    fetch request and word address
//   imem_gnt_i                  request accepted this cycle
//   imem_rvalid_i/imem_rdata_i  in-order read response
//   redirect_valid_i/_pc_i      branch/jump redirect and target
//   id_valid_o/id_instr_o/id_pc_o  instruction presented to decode
//   id_ready_i                  decode accepts the presented instruction
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    input  logic        id_ready_i
);
    localparam int                PTR_W   = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [31:0]       NOP     = 32'h0000_0013;
    localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0]  C_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  P_ONE   = PTR_W'(1);

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_resp_pc;   // address of the next response that will be kept
    logic [CNT_W-1:0] r_out;       // granted requests whose response has not returned
    logic [CNT_W-1:0] r_disc;      // in-flight responses to drop after a redirect
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [31:0]      r_buf_instr [BUF_DEPTH];
    logic [31:0]      r_buf_pc    [BUF_DEPTH];

    logic [CNT_W:0]   w_inflight;
    logic [31:0]      w_redirect_pc;
    logic             w_req;
    logic             w_grant;
    logic             w_rsp;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;

    assign w_redirect_pc = redirect_pc_i & ~32'h3;
    assign w_inflight    = {1'b0, r_count} + {1'b0, r_out};
    assign w_empty       = (r_count == '0);

    // Space is reserved for every outstanding request, so the buffer can never overflow.
    assign w_req   = (r_state == S_FETCH) && !redirect_valid_i && (w_inflight < {1'b0, C_DEPTH});
    assign w_grant = w_req && imem_gnt_i;
    // A response with nothing outstanding is ignored so the counters cannot underflow.
    assign w_rsp   = imem_rvalid_i && (r_out != '0);
    assign w_push  = w_rsp && !redirect_valid_i && (r_disc == '0);
    assign w_pop   = id_valid_o && id_ready_i;

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc;
    assign id_valid_o  = !w_empty && !redirect_valid_i;
    assign id_instr_o  = w_empty ? NOP  : r_buf_instr[r_head];
    assign id_pc_o     = w_empty ? r_pc : r_buf_pc[r_head];

    // Leaving FETCH while a request waits for grant would break request stability,
    // so the FSM stays until that request is accepted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (fetch_en_i) w_state_nxt = S_FETCH;
            S_FETCH: if (!fetch_en_i && !(w_req && !imem_gnt_i)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_resp_pc <= RESET_PC;
            r_out     <= '0;
            r_disc    <= '0;
            r_count   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid_i) begin
                // No grant is possible in a redirect cycle; everything still in
                // flight after this cycle's response belongs to the old path.
                r_pc      <= w_redirect_pc;
                r_resp_pc <= w_redirect_pc;
                r_out     <= r_out - CNT_W'(w_rsp);
                r_disc    <= r_out - CNT_W'(w_rsp);
                r_count   <= '0;
                r_head    <= '0;
                r_tail    <= '0;
            end else begin
                if (w_grant) r_pc <= r_pc + 32'd4;
                r_out <= r_out + CNT_W'(w_grant) - CNT_W'(w_rsp);
                if (w_rsp && (r_disc != '0)) r_disc <= r_disc - C_ONE;
                if (w_push) begin
                    r_tail    <= r_tail + P_ONE;
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_pop) r_head <= r_head + P_ONE;
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // Buffer payload needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_instr[r_tail] <= imem_rdata_i;
            r_buf_pc[r_tail]    <= r_resp_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard testbench for if_fetch_unit
module tb_if_fetch_unit;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        id_ready_i;

    if_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .id_valid_o(id_valid_o), .id_instr_o(id_instr_o), .id_pc_o(id_pc_o),
        .id_ready_i(id_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } imem_t;

    imem_t       imem_q[$];      // granted requests awaiting their memory response
    logic [63:0] exp_q[$];       // expected {pc, instr} deliveries to decode
    logic [31:0] deliv_log[$];
    logic [31:0] model_pc;
    int          model_disc;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_grants = 0;
    int          n_deliv  = 0;
    int          cyc      = 0;
    int          p_gnt, p_rvalid, p_ready;
    bit          rd_now;
    logic [31:0] rd_target;
    bit          pend;
    logic [31:0] pend_addr;
    logic [31:0] hold_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h0000_0013;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        bit resp_now;
        @(negedge clk);
        cyc++;
        resp_now = 1'b0;
        if (imem_q.size() > 0 && imem_q[0].cyc < cyc && $urandom_range(99) < p_rvalid) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(imem_q[0].addr);
            void'(imem_q.pop_front());
            resp_now = 1'b1;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        imem_gnt_i       = ($urandom_range(99) < p_gnt);
        id_ready_i       = ($urandom_range(99) < p_ready);
        redirect_valid_i = rd_now;
        redirect_pc_i    = rd_target;
        #1;
        chk(imem_addr_o[1:0] === 2'b00, "addr_align", imem_addr_o, {imem_addr_o[31:2], 2'b00});
        if (imem_req_o === 1'b1)
            chk(exp_q.size() + model_disc < DEPTH, "occupancy", exp_q.size() + model_disc, DEPTH - 1);
        if (pend && !redirect_valid_i) begin
            chk(imem_req_o === 1'b1, "req_hold", imem_req_o, 1);
            chk(imem_addr_o === pend_addr, "addr_hold", imem_addr_o, pend_addr);
        end
        if (resp_now && model_disc > 0) model_disc--;
        if (redirect_valid_i) begin
            chk(imem_req_o === 1'b0, "req_in_redirect", imem_req_o, 0);
            chk(id_valid_o === 1'b0, "valid_in_redirect", id_valid_o, 0);
            exp_q.delete();
            model_pc   = rd_target & ~32'h3;
            model_disc = imem_q.size();
            pend       = 1'b0;
        end else begin
            if (imem_req_o === 1'b1 && imem_gnt_i) begin
                chk(imem_addr_o === model_pc, "fetch_addr", imem_addr_o, model_pc);
                exp_q.push_back({model_pc, mem_word(model_pc)});
                imem_q.push_back('{addr: imem_addr_o, cyc: cyc});
                model_pc = model_pc + 32'd4;
                n_grants++;
            end
            pend      = (imem_req_o === 1'b1) && !imem_gnt_i;
            pend_addr = imem_addr_o;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk(imem_req_o === 1'b0, "rst_req", imem_req_o, 0);
        chk(id_valid_o === 1'b0, "rst_valid", id_valid_o, 0);
        chk(id_instr_o === NOP, "rst_instr", id_instr_o, NOP);
        chk(id_pc_o === RST_PC, "rst_pc", id_pc_o, RST_PC);
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0; id_ready_i = 1'b0;
        redirect_valid_i = 1'b0; rd_now = 1'b0;
        exp_q.delete(); imem_q.delete();
        model_pc = RST_PC; model_disc = 0; pend = 1'b0; n_grants = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever decode takes an instruction.
    always begin
        logic [63:0] e;
        @(negedge clk);
        #2;
        if (rst_n === 1'b1 && id_valid_o === 1'b1 && id_ready_i === 1'b1) begin
            n_deliv++;
            deliv_log.push_back(id_pc_o);
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_delivery", id_pc_o, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk(id_pc_o === e[63:32], "id_pc", id_pc_o, e[63:32]);
                chk(id_instr_o === e[31:0], "id_instr", id_instr_o, e[31:0]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        rst_n = 1'b0; fetch_en_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        imem_rdata_i = '0; redirect_valid_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0;
        rd_now = 1'b0; rd_target = '0; pend = 1'b0; pend_addr = '0;
        model_pc = RST_PC; model_disc = 0;
        repeat (2) @(negedge clk);
        #1;
        chk(imem_req_o === 1'b0, "init_req", imem_req_o, 0);
        chk(id_valid_o === 1'b0, "init_valid", id_valid_o, 0);
        chk(id_instr_o === NOP, "init_instr", id_instr_o, NOP);
        chk(id_pc_o === RST_PC, "init_pc", id_pc_o, RST_PC);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running: sequential pcs across the 2^32 wrap, one per cycle once primed.
        fetch_en_i = 1'b1; p_gnt = 100; p_rvalid = 100; p_ready = 100;
        step();
        chk(id_valid_o === 1'b0, "first_valid", id_valid_o, 0);
        chk(id_pc_o === RST_PC, "first_pc", id_pc_o, RST_PC);
        deliv_log.delete();
        repeat (5) step();
        d0 = n_deliv;
        repeat (10) step();
        chk(n_deliv - d0 == 10, "throughput", n_deliv - d0, 10);
        chk(deliv_log.size() >= 3 && deliv_log[2] === 32'h0000_0000, "wrap_pc",
            deliv_log.size() >= 3 ? deliv_log[2] : 32'hX, 32'h0);

        // Decode stalled: exactly DEPTH grants, head held, then in-order drain.
        do_reset();
        p_ready = 0;
        repeat (10) step();
        chk(n_grants == DEPTH, "stall_grants", n_grants, DEPTH);
        chk(imem_req_o === 1'b0, "stall_req_low", imem_req_o, 0);
        chk(id_valid_o === 1'b1, "stall_valid", id_valid_o, 1);
        chk(id_pc_o === RST_PC, "stall_head_pc", id_pc_o, RST_PC);
        chk(id_instr_o === mem_word(RST_PC), "stall_head_instr", id_instr_o, mem_word(RST_PC));
        p_ready = 100;
        repeat (10) step();

        // Redirect with two requests outstanding.
        do_reset();
        p_rvalid = 0;
        step(); step();
        chk(n_grants == 2, "two_outstanding", n_grants, 2);
        p_rvalid = 100; rd_now = 1'b1; rd_target = 32'h0000_1002;
        step();
        rd_now = 1'b0; deliv_log.delete();
        step();
        chk(imem_addr_o === 32'h0000_1000, "redirect_addr", imem_addr_o, 32'h0000_1000);
        repeat (10) step();
        chk(deliv_log.size() > 0 && deliv_log[0] === 32'h0000_1000, "redirect_first_pc",
            deliv_log.size() > 0 ? deliv_log[0] : 32'hX, 32'h0000_1000);

        // Redirect coinciding with a response and a ready decode, then back-to-back redirects.
        rd_now = 1'b1; rd_target = 32'h2000_0000;
        step();
        rd_now = 1'b0;
        repeat (3) step();
        rd_now = 1'b1; rd_target = 32'h0000_0300; step();
        rd_target = 32'h0000_0401; step();
        rd_now = 1'b0; deliv_log.delete();
        repeat (10) step();
        chk(deliv_log.size() > 0 && deliv_log[0] === 32'h0000_0400, "b2b_redirect_pc",
            deliv_log.size() > 0 ? deliv_log[0] : 32'hX, 32'h0000_0400);

        // Grant withheld: address stays put, then reset lands mid-stall.
        p_gnt = 0;
        step();
        hold_addr = imem_addr_o;
        repeat (5) step();
        chk(imem_addr_o === hold_addr, "gnt_stall_addr", imem_addr_o, hold_addr);
        do_reset();

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 5) fetch_en_i = ~fetch_en_i;
            p_gnt = 70; p_rvalid = 60; p_ready = 70;
            rd_now = ($urandom_range(99) < 3);
            rd_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            if ($urandom_range(999) == 0) do_reset();
            else step();
        end

        // Drain everything that was issued.
        rd_now = 1'b0; fetch_en_i = 1'b0; p_gnt = 100; p_rvalid = 100; p_ready = 100;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || imem_q.size() != 0); i++) step();
        chk(exp_q.size() == 0, "drain_complete", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
